// File: rtl/aes128_ctr_decrypt_stream.sv
// aes128_top_level_alt: iterative AES-128 encryption core, one round per clock.
//   pi_clk, pi_rst (async, active-high), pi_start (1-cycle pulse latching
//   pi_input_key / pi_data), po_data (ciphertext), po_end_of_encryption
//   (1-cycle pulse, po_data valid from then on).
// aes128_ctr_decrypt_stream: AES-128 CTR-mode decryptor. Builds the keystream
//   E(K, {nonce, counter}) with one core, buffers one keystream block and XORs
//   it into each accepted ciphertext block.
//   pi_init latches key/nonce/counter and restarts; pi_ct_* / po_ct_ready is
//   the ciphertext handshake; po_pt_* / pi_pt_ready is the plaintext
//   handshake; po_busy flags an encryption in flight; po_cnt_wrap is sticky
//   once the counter wraps.

module aes128_top_level_alt (
    input  logic         pi_clk,
    input  logic         pi_rst,
    input  logic         pi_start,
    input  logic [127:0] pi_input_key,
    input  logic [127:0] pi_data,
    output logic [127:0] po_data,
    output logic         po_end_of_encryption
);
    logic [127:0] st, rk, next_rk, sb, sr, mc, next_st;
    logic [31:0]  w3, tw, nw0, nw1, nw2, nw3;
    logic [7:0]   rc;
    logic [3:0]   rnd;
    logic         run;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, m;
        p = '0;
        m = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ m;
            m = xt(m);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq  = x;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Round key for the current round is expanded on the fly from the previous one.
    always_comb begin
        w3  = rk[31:0];
        tw  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        nw0 = rk[127:96] ^ tw;
        nw1 = rk[95:64] ^ nw0;
        nw2 = rk[63:32] ^ nw1;
        nw3 = rk[31:0] ^ nw2;
        next_rk = {nw0, nw1, nw2, nw3};
        sb = '0;
        sr = '0;
        mc = '0;
        for (int unsigned i = 0; i < 16; i++)
            sb[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
        for (int unsigned c = 0; c < 4; c++)
            for (int unsigned r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        for (int unsigned c = 0; c < 4; c++)
            mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
        next_st = ((rnd == 4'd10) ? sr : mc) ^ next_rk;
    end

    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            st                   <= '0;
            rk                   <= '0;
            rc                   <= '0;
            rnd                  <= '0;
            run                  <= 1'b0;
            po_data              <= '0;
            po_end_of_encryption <= 1'b0;
        end else begin
            po_end_of_encryption <= 1'b0;
            if (pi_start) begin
                st  <= pi_data ^ pi_input_key;
                rk  <= pi_input_key;
                rc  <= 8'h01;
                rnd <= 4'd1;
                run <= 1'b1;
            end else if (run) begin
                st  <= next_st;
                rk  <= next_rk;
                rc  <= xt(rc);
                rnd <= rnd + 4'd1;
                if (rnd == 4'd10) begin
                    run                  <= 1'b0;
                    po_end_of_encryption <= 1'b1;
                    po_data              <= next_st;
                end
            end
        end
    end
endmodule

module aes128_ctr_decrypt_stream #(
    parameter int unsigned CNT_W      = 8,
    parameter bit          ALLOW_WRAP = 1'b0
) (
    input  logic               pi_clk,
    input  logic               pi_rst,
    input  logic               pi_init,
    input  logic [127:0]       pi_input_key,
    input  logic [127-CNT_W:0] pi_nonse,
    input  logic [CNT_W-1:0]   pi_counter,
    input  logic               pi_ct_valid,
    input  logic [127:0]       pi_ct_data,
    output logic               po_ct_ready,
    output logic               po_pt_valid,
    output logic [127:0]       po_pt_data,
    input  logic               pi_pt_ready,
    output logic               po_busy,
    output logic               po_cnt_wrap
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_HAVE_KS, S_DRAIN, S_HALT} state_t;

    state_t             state;
    logic [127:0]       key_r, ks_r, core_out;
    logic [127-CNT_W:0] nonce_r;
    logic [CNT_W-1:0]   ctr_r;
    logic               core_done, ct_hs, pt_hs;

    aes128_top_level_alt u_core (
        .pi_clk               (pi_clk),
        .pi_rst               (pi_rst),
        .pi_start             (state == S_START),
        .pi_input_key         (key_r),
        .pi_data              ({nonce_r, ctr_r}),
        .po_data              (core_out),
        .po_end_of_encryption (core_done)
    );

    assign po_ct_ready = (state == S_HAVE_KS) && (!po_pt_valid || pi_pt_ready);
    assign po_busy     = (state == S_START) || (state == S_WAIT) || (state == S_DRAIN);
    assign ct_hs       = pi_ct_valid && po_ct_ready;
    assign pt_hs       = po_pt_valid && pi_pt_ready;

    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            state       <= S_IDLE;
            key_r       <= '0;
            nonce_r     <= '0;
            ctr_r       <= '0;
            ks_r        <= '0;
            po_pt_valid <= 1'b0;
            po_pt_data  <= '0;
            po_cnt_wrap <= 1'b0;
        end else if (pi_init) begin
            key_r       <= pi_input_key;
            nonce_r     <= pi_nonse;
            ctr_r       <= pi_counter;
            ks_r        <= '0;
            po_pt_valid <= 1'b0;
            po_cnt_wrap <= 1'b0;
            // A core result arriving this very cycle leaves nothing to drain;
            // in START the core is launched on this edge, so it must be drained.
            if (state == S_START ||
                ((state == S_WAIT || state == S_DRAIN) && !core_done))
                state <= S_DRAIN;
            else
                state <= S_START;
        end else begin
            if (pt_hs) po_pt_valid <= 1'b0;
            case (state)
                S_IDLE:  state <= S_IDLE;
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (core_done) begin
                        ks_r  <= core_out;
                        state <= S_HAVE_KS;
                    end
                end
                S_HAVE_KS: begin
                    if (ct_hs) begin
                        po_pt_data  <= pi_ct_data ^ ks_r;
                        po_pt_valid <= 1'b1;
                        if (&ctr_r) begin
                            ctr_r       <= '0;
                            po_cnt_wrap <= 1'b1;
                            state       <= ALLOW_WRAP ? S_START : S_HALT;
                        end else begin
                            ctr_r <= ctr_r + 1'b1;
                            state <= S_START;
                        end
                    end
                end
                S_DRAIN: if (core_done) state <= S_START;
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
